// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with runtime almost-full/almost-empty
// thresholds, standard or first-word-fall-through read, pulse and sticky
// error flags, and a synchronous flush. All status outputs are registered
// and derived from the occupancy the FIFO will have after the current edge.
module sync_fifo_prog #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [1:0]            err_sticky,
    input  logic                  err_clr
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    // Storage is deliberately not reset; only pointers and flags are.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  full_q;
    logic                  empty_q;
    logic                  af_q;
    logic                  ae_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic [1:0]            sticky_q;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  wr_rej;
    logic                  rd_rej;

    // Occupancy after this edge given which sides are accepted. A flush
    // overrides everything and empties the FIFO.
    function automatic logic [ADDR_WIDTH:0] next_level(
        input logic [ADDR_WIDTH:0] cur,
        input logic                do_wr,
        input logic                do_rd,
        input logic                do_flush
    );
        logic [ADDR_WIDTH:0] lvl;
        lvl = cur;
        if (do_flush) begin
            lvl = '0;
        end else if (do_wr && !do_rd) begin
            lvl = cur + 1'b1;
        end else if (do_rd && !do_wr) begin
            lvl = cur - 1'b1;
        end
        return lvl;
    endfunction

    // Accept/reject decisions use the registered full/empty seen at this edge;
    // flush and reset suppress both sides and any error pulse.
    always_comb begin
        wr_acc    = wr_en && !full_q  && !flush && !reset;
        rd_acc    = rd_en && !empty_q && !flush && !reset;
        wr_rej    = wr_en &&  full_q  && !flush;
        rd_rej    = rd_en &&  empty_q && !flush;
        count_nxt = next_level(count_q, wr_acc, rd_acc, flush);
    end

    // Occupancy and status flags, all computed from the next occupancy so
    // they always agree with count in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            count_q <= count_nxt;
            full_q  <= (count_nxt == DEPTH_C);
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= af_thresh);
            ae_q    <= (count_nxt <= ae_thresh);
        end
    end

    // Read and write pointers; natural wrap at DEPTH-1 -> 0.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; never lands on the head entry unless the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // One-cycle error pulses and their sticky copies; a new error wins over
    // err_clr in the same cycle, flush leaves the stickies alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            sticky_q <= 2'b00;
        end else begin
            ovf_q    <= wr_rej;
            unf_q    <= rd_rej;
            sticky_q <= (err_clr ? 2'b00 : sticky_q) | {wr_rej, rd_rej};
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_WIDTH-1:0] dout_p1;
            logic                  vld_p1;

            // Registered read: the head is captured one cycle after an accepted
            // read; data holds otherwise, including across a flush.
            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_p1 <= '0;
                    vld_p1  <= 1'b0;
                end else if (flush) begin
                    vld_p1  <= 1'b0;
                end else begin
                    vld_p1 <= rd_acc;
                    if (rd_acc) begin
                        dout_p1 <= mem[rd_ptr];
                    end
                end
            end

            assign data_out = dout_p1;
            assign rd_valid = vld_p1;
        end else begin : g_fwft
            logic [DATA_WIDTH-1:0] head;
            logic [DATA_WIDTH-1:0] last_p1;

            assign head = mem[rd_ptr];

            // Remember the word being presented so data_out holds it once the
            // FIFO runs empty or is flushed, and reads zero after reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    last_p1 <= '0;
                end else if (!empty_q) begin
                    last_p1 <= head;
                end
            end

            assign data_out = empty_q ? last_p1 : head;
            assign rd_valid = !empty_q;
        end
    endgenerate

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign err_sticky   = sticky_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: a standard-read instance and an FWFT
// instance share stimulus; a vector table covers fill/drain/simultaneous/wrap,
// hand sequences cover thresholds, FWFT, flush and reset mid-burst.
module tb_sync_fifo_prog;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       wr_en;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] data_in;
    logic [4:0] af_thresh;
    logic [4:0] ae_thresh;

    logic [7:0] d0_dout, d1_dout;
    logic       d0_vld, d1_vld;
    logic [4:0] d0_cnt, d1_cnt;
    logic       d0_full, d1_full, d0_empty, d1_empty;
    logic       d0_af, d1_af, d0_ae, d1_ae;
    logic       d0_ovf, d1_ovf, d0_unf, d1_unf;
    logic [1:0] d0_st, d1_st;

    int n_cmp;
    int n_bad;

    sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(d0_dout), .rd_valid(d0_vld), .af_thresh(af_thresh),
        .ae_thresh(ae_thresh), .count(d0_cnt), .full(d0_full), .empty(d0_empty),
        .almost_full(d0_af), .almost_empty(d0_ae), .overflow(d0_ovf),
        .underflow(d0_unf), .err_sticky(d0_st), .err_clr(err_clr)
    );

    sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(d1_dout), .rd_valid(d1_vld), .af_thresh(af_thresh),
        .ae_thresh(ae_thresh), .count(d1_cnt), .full(d1_full), .empty(d1_empty),
        .almost_full(d1_af), .almost_empty(d1_ae), .overflow(d1_ovf),
        .underflow(d1_unf), .err_sticky(d1_st), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic       fl;
        logic       ec;
        int         cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
        logic [1:0] st;
        logic       vld;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic w, input logic r, input logic [7:0] d,
                                input logic f, input logic ec, input int cnt,
                                input logic fu, input logic em, input logic af,
                                input logic ae, input logic ov, input logic un,
                                input logic [1:0] st, input logic vl,
                                input logic [7:0] dq);
        vec_t v;
        v.wr = w; v.rd = r; v.din = d; v.fl = f; v.ec = ec; v.cnt = cnt;
        v.full = fu; v.empty = em; v.af = af; v.ae = ae; v.ovf = ov; v.unf = un;
        v.st = st; v.vld = vl; v.dout = dq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 ns later.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                       input logic f, input logic ec);
        wr_en = w; rd_en = r; data_in = d; flush = f; err_clr = ec;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        data_in = 8'h00; af_thresh = 5'd14; ae_thresh = 5'd2;

        // Test 1: fill 0x01..0x10, then a rejected 17th write.
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1, 0, 8'(i + 1), 0, 0, i + 1, (i == 15), 0, (i + 1 >= 14),
                             (i + 1 <= 2), 0, 0, 2'b00, 0, 8'h00));
        tbl.push_back(mk(1, 0, 8'h99, 0, 0, 16, 1, 0, 1, 0, 1, 0, 2'b10, 0, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 16, 1, 0, 1, 0, 0, 0, 2'b10, 0, 8'h00));
        // Test 2: drain in order with one-cycle latency, underflow, err_clr.
        for (int j = 0; j < 16; j++)
            tbl.push_back(mk(0, 1, 8'h00, 0, 0, 15 - j, 0, (j == 15), (15 - j >= 14),
                             (15 - j <= 2), 0, 0, 2'b10, 1, 8'(j + 1)));
        tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0, 1, 2'b11, 0, 8'h10));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 0, 2'b00, 0, 8'h10));
        // Test 3: count 5 then ten simultaneous read+write cycles.
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1, 0, 8'(8'h20 + k), 0, 0, k + 1, 0, 0, 0, (k + 1 <= 2),
                             0, 0, 2'b00, 0, 8'h10));
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(1, 1, 8'(8'h25 + k), 0, 0, 5, 0, 0, 0, 0, 0, 0, 2'b00, 1,
                             8'(8'h20 + k)));
        for (int k = 0; k < 11; k++)
            tbl.push_back(mk(1, 0, 8'(8'h2F + k), 0, 0, 6 + k, (k == 10), 0, (6 + k >= 14),
                             0, 0, 0, 2'b00, 0, 8'h29));
        // Full with both requests: read wins, write rejected.
        tbl.push_back(mk(1, 1, 8'h3A, 0, 0, 15, 0, 0, 1, 0, 1, 0, 2'b10, 1, 8'h2A));
        for (int j = 0; j < 15; j++)
            tbl.push_back(mk(0, 1, 8'h00, 0, 0, 14 - j, 0, (j == 14), (14 - j >= 14),
                             (14 - j <= 2), 0, 0, 2'b10, 1, 8'(8'h2B + j)));
        // Empty with both requests: write wins, read rejected.
        tbl.push_back(mk(1, 1, 8'h50, 0, 0, 1, 0, 0, 0, 1, 0, 1, 2'b11, 0, 8'h39));
        tbl.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 0, 2'b00, 1, 8'h50));
        // New underflow in the same cycle as err_clr keeps its sticky bit.
        tbl.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 1, 2'b01, 0, 8'h50));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 1, 0, 0, 2'b00, 0, 8'h50));
        // Test 4: 40 interleaved write/read pairs across pointer wrap.
        for (int k = 0; k < 40; k++) begin
            tbl.push_back(mk(1, 0, 8'(8'h60 + k), 0, 0, 1, 0, 0, 0, 1, 0, 0, 2'b00, 0,
                             (k == 0) ? 8'h50 : 8'(8'h60 + k - 1)));
            tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 1,
                             8'(8'h60 + k)));
        end

        // Reset state.
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        chk("rst.count", 32'(d0_cnt), 0);
        chk("rst.empty", 32'(d0_empty), 1);
        chk("rst.full", 32'(d0_full), 0);
        chk("rst.af", 32'(d0_af), 0);
        chk("rst.ae", 32'(d0_ae), 1);
        chk("rst.flags", {28'd0, d0_ovf, d0_unf, d0_st}, 0);
        chk("rst.rdv", 32'(d0_vld), 0);
        chk("rst.dout", 32'(d0_dout), 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].wr, tbl[i].rd, tbl[i].din, tbl[i].fl, tbl[i].ec);
            chk($sformatf("v%0d.count", i), 32'(d0_cnt), 32'(tbl[i].cnt));
            chk($sformatf("v%0d.full", i), 32'(d0_full), 32'(tbl[i].full));
            chk($sformatf("v%0d.empty", i), 32'(d0_empty), 32'(tbl[i].empty));
            chk($sformatf("v%0d.af", i), 32'(d0_af), 32'(tbl[i].af));
            chk($sformatf("v%0d.ae", i), 32'(d0_ae), 32'(tbl[i].ae));
            chk($sformatf("v%0d.ovf", i), 32'(d0_ovf), 32'(tbl[i].ovf));
            chk($sformatf("v%0d.unf", i), 32'(d0_unf), 32'(tbl[i].unf));
            chk($sformatf("v%0d.sticky", i), 32'(d0_st), 32'(tbl[i].st));
            chk($sformatf("v%0d.rdv", i), 32'(d0_vld), 32'(tbl[i].vld));
            chk($sformatf("v%0d.dout", i), 32'(d0_dout), 32'(tbl[i].dout));
        end

        // Test 5: thresholds 12/3 during a 0->16 fill, then runtime changes.
        af_thresh = 5'd12; ae_thresh = 5'd3;
        do_reset();
        chk("thr.rst.af", 32'(d0_af), 0);
        chk("thr.rst.ae", 32'(d0_ae), 1);
        for (int n = 1; n <= 16; n++) begin
            cyc(1'b1, 1'b0, 8'(n), 1'b0, 1'b0);
            chk($sformatf("thr%0d.count", n), 32'(d0_cnt), 32'(n));
            chk($sformatf("thr%0d.ae", n), 32'(d0_ae), 32'(n <= 3));
            chk($sformatf("thr%0d.af", n), 32'(d0_af), 32'(n >= 12));
        end
        af_thresh = 5'd0;
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("thr.af0", 32'(d0_af), 1);
        af_thresh = 5'd17;
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("thr.af17", 32'(d0_af), 0);
        ae_thresh = 5'd16;
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("thr.ae16", 32'(d0_ae), 1);
        ae_thresh = 5'd15;
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("thr.ae15", 32'(d0_ae), 0);
        af_thresh = 5'd12; ae_thresh = 5'd3;

        // Test 6: FWFT instance, flush and reset mid-burst.
        do_reset();
        chk("fw.rst.dout", 32'(d1_dout), 0);
        chk("fw.rst.rdv", 32'(d1_vld), 0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("fw.unf", 32'(d1_unf), 1);
        chk("fw.unf.sticky", 32'(d1_st), 32'h1);
        cyc(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        chk("fw.a5.dout", 32'(d1_dout), 32'hA5);
        chk("fw.a5.rdv", 32'(d1_vld), 1);
        chk("fw.a5.count", 32'(d1_cnt), 1);
        for (int k = 1; k < 8; k++)
            cyc(1'b1, 1'b0, 8'(8'hA5 + k), 1'b0, 1'b0);
        chk("fw.fill.count", 32'(d1_cnt), 8);
        chk("fw.fill.dout", 32'(d1_dout), 32'hA5);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("fw.pop.dout", 32'(d1_dout), 32'hA6);
        chk("fw.pop.count", 32'(d1_cnt), 7);
        chk("std.pop.dout", 32'(d0_dout), 32'hA5);
        cyc(1'b1, 1'b0, 8'hAD, 1'b0, 1'b0);
        chk("fw.refill.count", 32'(d1_cnt), 8);
        cyc(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
        chk("fl.count", 32'(d1_cnt), 0);
        chk("fl.empty", 32'(d1_empty), 1);
        chk("fl.full", 32'(d1_full), 0);
        chk("fl.ae", 32'(d1_ae), 1);
        chk("fl.af", 32'(d1_af), 0);
        chk("fl.pulses", {30'd0, d1_ovf, d1_unf}, 0);
        chk("fl.sticky", 32'(d1_st), 32'h1);
        chk("fl.fw.rdv", 32'(d1_vld), 0);
        chk("fl.fw.dout", 32'(d1_dout), 32'hA6);
        chk("fl.std.rdv", 32'(d0_vld), 0);
        chk("fl.std.dout", 32'(d0_dout), 32'hA5);
        for (int k = 0; k < 4; k++)
            cyc(1'b1, 1'b0, 8'(8'hB0 + k), 1'b0, 1'b0);
        chk("burst.count", 32'(d1_cnt), 4);
        chk("burst.fw.dout", 32'(d1_dout), 32'hB0);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 8'hB4, 1'b0, 1'b0);
        reset = 1'b0;
        chk("mrst.count", 32'(d1_cnt), 0);
        chk("mrst.empty", 32'(d1_empty), 1);
        chk("mrst.ae", 32'(d1_ae), 1);
        chk("mrst.af", 32'(d1_af), 0);
        chk("mrst.sticky", 32'(d1_st), 0);
        chk("mrst.fw.dout", 32'(d1_dout), 0);
        chk("mrst.fw.rdv", 32'(d1_vld), 0);
        chk("mrst.std.dout", 32'(d0_dout), 0);
        chk("mrst.std.rdv", 32'(d0_vld), 0);

        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
